// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared types and helpers for the PISO stream serializer.
//               - piso_state_e : frame FSM states (IDLE, SHIFT)
//               - cnt_w()      : bit-index counter width for a given word width
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  // Wide enough to hold indices 0..WIDTH, which also covers the optional
  // parity bit at index WIDTH.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : piso_bit_counter
// Description : Frame bit-index counter. Clears on accept/frame end, advances
//               on each enabled shift and saturates at the terminal count.
// Ports       : clk_i       - clock
//               rst_ni      - asynchronous active-low reset
//               clr_i       - force index to 0 (accept or frame end)
//               inc_i       - advance index by one
//               last_o      - index equals FL-1 (final frame bit)
//               pre_last_o  - index equals FL-2 (next advance reaches last)
// Revision    : 1.0 - initial release
// ============================================================================
module piso_bit_counter #(
  parameter int FL = 8,
  parameter int CW = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o,
  output logic pre_last_o
);

  localparam logic [CW-1:0] c_last     = CW'(FL - 1);
  localparam logic [CW-1:0] c_pre_last = CW'(FL - 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last_o     = (cnt_q == c_last);
  assign pre_last_o = (cnt_q == c_pre_last);

  // Saturate at the terminal count; the frame FSM clears it when done.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !last_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : piso_bit_counter
`default_nettype wire

// File: rtl/piso_stream_ser.sv
`default_nettype none
// ============================================================================
// Module      : piso_stream_ser
// Description : Parametrised parallel-in/serial-out serializer. Accepts a
//               WIDTH-bit word over a valid/ready handshake and emits it one
//               bit per enabled clock with q_valid/q_last framing.
//               Optional build macro PISO_PARITY_EN appends an even-parity
//               bit (XOR of the word) after the data bits.
// Parameters  : WIDTH     - word width (>=2)
//               MSB_FIRST - 1: bit WIDTH-1 first, 0: bit 0 first
// Ports       : clk_i        - clock
//               rst_ni       - asynchronous active-low reset
//               d_i          - parallel word
//               load_valid_i - d_i is valid
//               load_ready_o - word can be accepted this cycle
//               shift_en_i   - advance one bit (0 = stall)
//               q_o          - serial data (registered)
//               q_valid_o    - q_o carries a frame bit
//               q_last_o     - q_o is the final frame bit
//               busy_o       - frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module piso_stream_ser
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic             shift_en_i,
  output logic             q_o,
  output logic             q_valid_o,
  output logic             q_last_o,
  output logic             busy_o
);

  localparam int c_cw = cnt_w(WIDTH);
`ifdef PISO_PARITY_EN
  localparam int c_fl = WIDTH + 1;
`else
  localparam int c_fl = WIDTH;
`endif

  piso_state_e      state_q;
  logic [WIDTH-1:0] sr_q;
  logic             q_q;
  logic             q_valid_q;
  logic             q_last_q;

  logic             w_last;
  logic             w_pre_last;
  logic             w_accept;
  logic             w_advance;
  logic             w_frame_end;
  logic             w_first_bit;
  logic             w_next_bit;
  logic             w_bit_after;
  logic [WIDTH-1:0] w_load_sr;
  logic [WIDTH-1:0] w_shift_sr;

  // Ready in IDLE, or when the last bit is leaving this cycle so the next
  // word follows with no gap.
  assign load_ready_o = (state_q == IDLE) ||
                        ((state_q == SHIFT) && w_last && shift_en_i);
  assign w_accept     = load_valid_i && load_ready_o;
  assign w_advance    = (state_q == SHIFT) && shift_en_i;
  assign w_frame_end  = w_advance && w_last && !w_accept;

  // The register holds the bits not yet presented; the first bit goes
  // straight to q at accept, so the register always shifts toward its
  // output end.
  if (MSB_FIRST) begin : g_msb_first
    assign w_first_bit = d_i[WIDTH-1];
    assign w_load_sr   = {d_i[WIDTH-2:0], 1'b0};
    assign w_next_bit  = sr_q[WIDTH-1];
    assign w_shift_sr  = {sr_q[WIDTH-2:0], 1'b0};
  end else begin : g_lsb_first
    assign w_first_bit = d_i[0];
    assign w_load_sr   = {1'b0, d_i[WIDTH-1:1]};
    assign w_next_bit  = sr_q[0];
    assign w_shift_sr  = {1'b0, sr_q[WIDTH-1:1]};
  end

`ifdef PISO_PARITY_EN
  // Parity is captured at accept so later changes on d_i cannot alter it.
  // The parity bit is the last frame bit, entered from index FL-2.
  logic par_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q <= 1'b0;
    end else if (w_accept) begin
      par_q <= ^d_i;
    end
  end

  assign w_bit_after = w_pre_last ? par_q : w_next_bit;
`else
  assign w_bit_after = w_next_bit;
`endif

  piso_bit_counter #(
    .FL (c_fl),
    .CW (c_cw)
  ) u_bit_counter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (w_accept || w_frame_end),
    .inc_i      (w_advance),
    .last_o     (w_last),
    .pre_last_o (w_pre_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      q_q       <= 1'b0;
      q_valid_q <= 1'b0;
      q_last_q  <= 1'b0;
    end else begin
      if (w_accept) begin
        state_q   <= SHIFT;
        sr_q      <= w_load_sr;
        q_q       <= w_first_bit;
        q_valid_q <= 1'b1;
        q_last_q  <= 1'b0;
      end else if (w_advance) begin
        if (w_last) begin
          state_q   <= IDLE;
          sr_q      <= '0;
          q_q       <= 1'b0;
          q_valid_q <= 1'b0;
          q_last_q  <= 1'b0;
        end else begin
          sr_q     <= w_shift_sr;
          q_q      <= w_bit_after;
          q_last_q <= w_pre_last;
        end
      end
    end
  end

  assign q_o       = q_q;
  assign q_valid_o = q_valid_q;
  assign q_last_o  = q_last_q;
  assign busy_o    = (state_q == SHIFT);

endmodule : piso_stream_ser
`default_nettype wire

// File: tb/tb_piso_stream_ser.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_stream_ser
// Description : Self-checking bench for piso_stream_ser (WIDTH=4). Runs an
//               MSB-first and an LSB-first instance from the same stimulus
//               against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_stream_ser;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] d;
  logic         load_valid;
  logic         shift_en;

  logic rdy_m, q_m, v_m, l_m, b_m;
  logic rdy_l, q_l, v_l, l_l, b_l;

  always #5 clk = ~clk;

  piso_stream_ser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk_i(clk), .rst_ni(rst_n), .d_i(d), .load_valid_i(load_valid),
    .load_ready_o(rdy_m), .shift_en_i(shift_en), .q_o(q_m),
    .q_valid_o(v_m), .q_last_o(l_m), .busy_o(b_m)
  );

  piso_stream_ser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk_i(clk), .rst_ni(rst_n), .d_i(d), .load_valid_i(load_valid),
    .load_ready_o(rdy_l), .shift_en_i(shift_en), .q_o(q_l),
    .q_valid_o(v_l), .q_last_o(l_l), .busy_o(b_l)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the frame in flight as an array of bits in emission
  // order, plus which bit is currently on the line.
  bit m_busy;
  int m_idx;
  bit m_bits_msb[FL];
  bit m_bits_lsb[FL];

  logic [7:0] seq_m;
  logic [7:0] seq_l;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_ready(input bit se);
    return !m_busy || ((m_idx == FL - 1) && se);
  endfunction

  task automatic model_load(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      m_bits_msb[i] = w[W-1-i];
      m_bits_lsb[i] = w[i];
    end
`ifdef PISO_PARITY_EN
    m_bits_msb[W] = ^w;
    m_bits_lsb[W] = ^w;
`endif
    m_idx  = 0;
    m_busy = 1'b1;
  endtask

  task automatic check_outputs();
    logic eq_m, eq_l, ev, el, er;
    eq_m = m_busy ? m_bits_msb[m_idx] : 1'b0;
    eq_l = m_busy ? m_bits_lsb[m_idx] : 1'b0;
    ev   = m_busy;
    el   = m_busy && (m_idx == FL - 1);
    er   = model_ready(shift_en);
    chk("q_msb",     q_m,   eq_m);
    chk("q_lsb",     q_l,   eq_l);
    chk("valid_msb", v_m,   ev);
    chk("valid_lsb", v_l,   ev);
    chk("last_msb",  l_m,   el);
    chk("last_lsb",  l_l,   el);
    chk("busy_msb",  b_m,   ev);
    chk("busy_lsb",  b_l,   ev);
    chk("ready_msb", rdy_m, er);
    chk("ready_lsb", rdy_l, er);
    seq_m = {seq_m[6:0], q_m};
    seq_l = {seq_l[6:0], q_l};
  endtask

  // One clock: apply inputs, check at the falling edge, advance the model
  // at the rising edge, then release 1 time unit later.
  task automatic cycle(input logic v, input logic [W-1:0] dd, input logic se);
    bit acc;
    load_valid = v;
    d          = dd;
    shift_en   = se;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    acc = v && model_ready(se);
    if (acc) begin
      model_load(dd);
    end else if (m_busy && se) begin
      if (m_idx == FL - 1) m_busy = 1'b0;
      else                 m_idx++;
    end
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    d          = '0;
    load_valid = 1'b0;
    shift_en   = 1'b1;
    m_busy     = 1'b0;
    m_idx      = 0;
    seq_m      = '0;
    seq_l      = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q",     q_m, 1'b0);
    chk("rst_valid", v_m, 1'b0);
    chk("rst_last",  l_m, 1'b0);
    chk("rst_busy",  b_m, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", rdy_m, 1'b1);
    @(posedge clk);
    #1;

    // Single word, both bit orders; then back to idle
    cycle(1'b1, 4'b1101, 1'b1);
    repeat (4) cycle(1'b0, 4'b0000, 1'b1);
    chk("seq1_msb", seq_m[3:0], 4'b1101);
    chk("seq1_lsb", seq_l[3:0], 4'b1011);
    repeat (FL) cycle(1'b0, 4'b0000, 1'b1);

    // Back-to-back with load_valid held
    cycle(1'b1, 4'b1101, 1'b1);
    repeat (FL) cycle(1'b1, 4'b0110, 1'b1);
    repeat (4) cycle(1'b0, 4'b1111, 1'b1);
`ifndef PISO_PARITY_EN
    chk("b2b_msb", seq_m, 8'b1101_0110);
    chk("b2b_lsb", seq_l, 8'b1011_0110);
`endif
    repeat (FL) cycle(1'b0, 4'b0000, 1'b1);

    // Stall during bit 1
    cycle(1'b1, 4'b1101, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    repeat (3) cycle(1'b0, 4'b0000, 1'b0);
    repeat (FL + 1) cycle(1'b0, 4'b0000, 1'b1);

    // Asynchronous reset in the middle of a frame
    cycle(1'b1, 4'b1101, 1'b1);
    repeat (2) cycle(1'b0, 4'b0000, 1'b1);
    load_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_q",     q_m, 1'b0);
    chk("mrst_valid", v_m, 1'b0);
    chk("mrst_busy",  b_m, 1'b0);
    chk("mrst_last",  l_m, 1'b0);
    m_busy = 1'b0;
    m_idx  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 4'b1010, 1'b1);
    repeat (4) cycle(1'b0, 4'b0000, 1'b1);
    chk("post_rst_msb", seq_m[3:0], 4'b1010);
    chk("post_rst_lsb", seq_l[3:0], 4'b0101);
    repeat (FL) cycle(1'b0, 4'b0000, 1'b1);

    // Randomised traffic with stalls and changing d
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (2 * FL + 4) cycle(1'b0, 4'b0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_piso_stream_ser
`default_nettype wire
